b_result_unloader: RTL and testbench
====================================

Name: b_result_unloader

Overview:
- Result-side counterpart of the matrix-multiplier calculation controller. The controller tags each B = A^T*A accumulator result with out_sel; this block is the consumer of that tag.
- Captures the 10 upper-triangle results (b11,b12,b13,b14,b22,b23,b24,b33,b34,b44) into a capture bank.
- On frame completion, moves the bank to a shadow bank and streams the full symmetric 4x4 matrix (16 beats, row-major) over a valid/ready interface.
- Sits between the MAC datapath output and the downstream host/readout logic.

Parameters:
DW, 16, width of each accumulator result and output word

Ports:
CLK  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
out_sel  input  4  result tag from the calc controller; 1..10 = b11,b12,b13,b14,b22,b23,b24,b33,b34,b44; 0 = none
acc_in  input  DW  accumulator sum, valid in the same cycle as out_sel
sclr  input  1  synchronous clear of the capture side
out_ready  input  1  downstream accepts the current beat
out_valid  output  1  beat valid
out_data  output  DW  B element for (out_row,out_col)
out_row  output  2  row index 0..3
out_col  output  2  column index 0..3
frame_done  output  1  one-cycle pulse after the last beat is accepted
overrun  output  1  sticky; a capture was dropped because the capture bank was frozen

Behaviour:
- Reset (async): clears all registers.
  - capture bank, shadow bank, mask[9:0], pending, beat counter = 0
  - state = IDLE; out_valid = 0, out_data = 0, out_row = 0, out_col = 0, frame_done = 0, overrun = 0
- Capture, at a clock edge:
  - out_sel in 1..10, pending = 0, sclr = 0: cap[out_sel-1] <= acc_in; mask[out_sel-1] <= 1.
  - Repeated index before the frame completes: value is overwritten; the mask is unchanged.
  - out_sel = 0 or 11..15: no effect.
- Frame completion: pending <= 1 at the edge after which mask = all ones.
- pending = 1:
  - capture bank is frozen;
  - any out_sel in 1..10 is dropped and sets overrun (sticky until reset).
- sclr (synchronous): clears mask, capture bank and pending.
  - sclr has priority over a simultaneous capture.
  - Does not affect the shadow bank, the stream in progress, or overrun.
- State machine, IDLE / STREAM:
  - IDLE & pending: copy cap -> shadow; clear mask and pending; beat = 0; go to STREAM; out_valid = 1 from that edge.
  - Latency: out_sel=10 (last missing index) sampled at edge N gives out_valid = 1 after edge N+1.
  - STREAM: beat b = 0..15; out_row = b[3:2], out_col = b[1:0].
  - Element mapping: out_data = shadow[idx(min(r,c), max(r,c))], with idx table (r,c) -> (0,0)0, (0,1)1, (0,2)2, (0,3)3, (1,1)4, (1,2)5, (1,3)6, (2,2)7, (2,3)8, (3,3)9.
  - Handshake: out_valid & out_ready at an edge advances the beat.
  - While out_ready = 0, out_data, out_row, out_col and out_valid hold stable.
  - Beat 15 accepted: frame_done = 1 for one cycle.
    - pending = 1 at that edge: go straight to the next frame (copy, beat 0, out_valid stays 1, no bubble).
    - otherwise: return to IDLE with out_valid = 0.
- Captures for the next frame continue into the capture bank while STREAM runs. This is double-buffering.
- Reset mid-stream aborts immediately; no frame_done.
- Registered outputs only; no combinational path from out_ready to out_valid.

Test Plan:
- Reset, then out_sel 1..10 on consecutive cycles with acc_in = 100+k, then out_ready = 1 constantly. Required:
  - out_valid rises the cycle after the out_sel=10 edge;
  - 16 beats in row-major order: 101,102,103,104, 102,105,106,107, 103,106,108,109, 104,107,109,110;
  - frame_done pulses once; out_valid then drops.
- Same frame with out_ready toggling 1,0,0,1 repeatedly. Required: data/row/col held during stalls; same 16-value sequence; exactly 16 accepts.
- Second full frame (acc_in = 200+k) captured while the first streams under out_ready = 0 stalls, then release. Required:
  - frame 2 (201..) starts the beat right after frame 1's beat 15 is accepted, with no bubble;
  - overrun = 0.
- Frame 2 complete and pending while frame 1 is still streaming; then out_sel=3, acc_in=999 arrives. Required: overrun = 1; frame 2 streams b13 = 203, not 999.
- Captures 1..5 done, sclr = 1 coincident with out_sel=6, then out_sel 1..10 with 300+k. Required: stream shows only 301..310 values; 6 is not pre-marked, so out_valid only after out_sel=10.
- Assert reset at beat 7 of a stream. Required: out_valid = 0 and all outputs = 0 immediately; frame_done is never asserted.

Source files
------------

// File: rtl/b_result_unloader.sv
// Captures the 10 upper-triangle B = A^T*A results tagged by out_sel, then streams the
// symmetric 4x4 matrix row-major from a shadow bank so the next frame can be captured meanwhile.
module b_result_unloader #(
    parameter int DW = 16
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic [3:0]    out_sel,
    input  logic [DW-1:0] acc_in,
    input  logic          sclr,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_row,
    output logic [1:0]    out_col,
    output logic          frame_done,
    output logic          overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] cap_q    [10];
    logic [DW-1:0] cap_d    [10];
    logic [DW-1:0] shadow_q [10];
    logic [DW-1:0] shadow_d [10];
    logic [9:0]    mask_q, mask_d;
    logic          pending_q, pending_d;
    logic [3:0]    beat_q, beat_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic          sel_hit;
    logic [3:0]    sel_idx;
    logic          load;

    // Upper-triangle storage index of beat (row, col), using min/max for symmetry.
    function automatic logic [3:0] elem_idx(input logic [3:0] b);
        logic [1:0] r, c, lo, hi;
        logic [3:0] idx;
        r   = b[3:2];
        c   = b[1:0];
        lo  = (r < c) ? r : c;
        hi  = (r < c) ? c : r;
        idx = 4'd0;
        case ({lo, hi})
            4'b0000: idx = 4'd0;
            4'b0001: idx = 4'd1;
            4'b0010: idx = 4'd2;
            4'b0011: idx = 4'd3;
            4'b0101: idx = 4'd4;
            4'b0110: idx = 4'd5;
            4'b0111: idx = 4'd6;
            4'b1010: idx = 4'd7;
            4'b1011: idx = 4'd8;
            4'b1111: idx = 4'd9;
            default: idx = 4'd0;
        endcase
        return idx;
    endfunction

    assign sel_hit = (out_sel >= 4'd1) && (out_sel <= 4'd10);
    assign sel_idx = out_sel - 4'd1;

    always_comb begin
        cap_d        = cap_q;
        shadow_d     = shadow_q;
        mask_d       = mask_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        state_d      = state_q;
        beat_d       = beat_q;
        valid_d      = valid_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        // Capture side; frozen once a complete frame is waiting for the shadow bank.
        if (sclr) begin
            mask_d    = '0;
            pending_d = 1'b0;
            for (int i = 0; i < 10; i++) cap_d[i] = '0;
        end else if (sel_hit) begin
            if (pending_q) begin
                overrun_d = 1'b1;
            end else begin
                cap_d[sel_idx]  = acc_in;
                mask_d[sel_idx] = 1'b1;
                if (&mask_d) pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pending_q) load = 1'b1;
            end
            STREAM: begin
                if (out_ready) begin
                    if (beat_q == 4'd15) begin
                        frame_done_d = 1'b1;
                        if (pending_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                            data_d  = '0;
                            beat_d  = 4'd0;
                        end
                    end else begin
                        beat_d = beat_q + 4'd1;
                        data_d = shadow_q[elem_idx(beat_q + 4'd1)];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Hand the captured frame to the shadow bank and start at beat 0 (b11).
        if (load) begin
            shadow_d  = cap_q;
            state_d   = STREAM;
            valid_d   = 1'b1;
            beat_d    = 4'd0;
            data_d    = cap_q[0];
            mask_d    = '0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 10; i++) begin
                cap_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            mask_q       <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= IDLE;
            beat_q       <= 4'd0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cap_q        <= cap_d;
            shadow_q     <= shadow_d;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
            beat_q       <= beat_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_row    = beat_q[3:2];
    assign out_col    = beat_q[1:0];
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_b_result_unloader.sv
// Directed bench for b_result_unloader: capture, streaming, stalls, double-buffering,
// overrun, sclr and mid-stream reset.
module tb_b_result_unloader;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  out_sel;
    logic [15:0] acc_in;
    logic        sclr;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        frame_done;
    logic        overrun;

    int tests = 0;
    int fails = 0;

    // Tag number k (1..10) expected at each row-major beat of the symmetric matrix.
    int kmap [16] = '{1, 2, 3, 4, 2, 5, 6, 7, 3, 6, 8, 9, 4, 7, 9, 10};

    always #5 CLK = ~CLK;

    b_result_unloader #(.DW(16)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .out_sel    (out_sel),
        .acc_in     (acc_in),
        .sclr       (sclr),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; out_sel is presented for exactly one rising edge.
    task automatic cap(input int sel, input int val);
        out_sel = 4'(sel);
        acc_in  = 16'(val);
        @(negedge CLK);
        out_sel = 4'd0;
    endtask

    task automatic cap_frame(input int base);
        for (int k = 1; k <= 10; k++) cap(k, base + k);
    endtask

    // mode 0: ready always high; mode 1: ready pattern 1,0,0,1 repeating.
    task automatic stream_frame(input int base, input int mode, input bit next_pending,
                                input int next_base);
        int beat;
        int cyc;
        bit rdy;
        beat = 0;
        cyc  = 0;
        while (beat < 16 && cyc < 300) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            out_ready = rdy;
            if (cyc > 0) chk("frame_done_low", frame_done, 0);
            if (out_valid) begin
                chk("row", out_row, beat / 4);
                chk("col", out_col, beat % 4);
                chk("data", out_data, base + kmap[beat]);
                if (rdy) beat++;
            end
            cyc++;
            @(negedge CLK);
        end
        chk("beats_accepted", beat, 16);
        out_ready = 1'b0;
        chk("frame_done_pulse", frame_done, 1);
        if (next_pending) begin
            chk("nobubble_valid", out_valid, 1);
            chk("nobubble_row", out_row, 0);
            chk("nobubble_col", out_col, 0);
            chk("nobubble_data", out_data, next_base + 1);
        end else begin
            chk("end_valid_low", out_valid, 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_row"}, out_row, 0);
        chk({tag, "_col"}, out_col, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        out_sel   = 4'd0;
        acc_in    = 16'd0;
        sclr      = 1'b0;
        out_ready = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        chk_all_zero("post_reset");

        // Frame 1, ready held high.
        cap_frame(100);
        chk("latency_pending", out_valid, 0);
        @(negedge CLK);
        chk("latency_valid", out_valid, 1);
        stream_frame(100, 0, 1'b0, 0);
        @(negedge CLK);
        chk("pulse_once", frame_done, 0);
        chk("idle_valid", out_valid, 0);

        // Same frame with ready toggling.
        cap_frame(100);
        @(negedge CLK);
        chk("latency_valid2", out_valid, 1);
        stream_frame(100, 1, 1'b0, 0);
        @(negedge CLK);
        chk("pulse_once2", frame_done, 0);

        // Frame 2 captured while frame 1 is stalled at beat 0, then an overrun.
        cap_frame(100);
        @(negedge CLK);
        cap_frame(200);
        chk("stall_valid", out_valid, 1);
        chk("stall_row", out_row, 0);
        chk("stall_col", out_col, 0);
        chk("stall_data", out_data, 101);
        chk("overrun_clear", overrun, 0);
        cap(3, 999);
        chk("overrun_set", overrun, 1);
        stream_frame(100, 0, 1'b1, 200);
        stream_frame(200, 0, 1'b0, 0);
        @(negedge CLK);
        chk("pulse_once3", frame_done, 0);
        chk("overrun_sticky", overrun, 1);

        // sclr wins over a coincident capture and forgets the marked indices.
        for (int k = 1; k <= 5; k++) cap(k, 500 + k);
        sclr = 1'b1;
        cap(6, 506);
        sclr = 1'b0;
        for (int k = 7; k <= 10; k++) cap(k, 300 + k);
        chk("sclr_no_valid0", out_valid, 0);
        @(negedge CLK);
        chk("sclr_no_valid1", out_valid, 0);
        @(negedge CLK);
        chk("sclr_no_valid2", out_valid, 0);
        for (int k = 1; k <= 6; k++) cap(k, 300 + k);
        chk("sclr_latency_pending", out_valid, 0);
        @(negedge CLK);
        chk("sclr_latency_valid", out_valid, 1);
        stream_frame(300, 1, 1'b0, 0);
        @(negedge CLK);

        // Reset asserted while beat 7 is on the bus.
        cap_frame(400);
        out_ready = 1'b1;
        @(negedge CLK);
        chk("r7_valid", out_valid, 1);
        repeat (7) @(negedge CLK);
        chk("r7_row", out_row, 1);
        chk("r7_col", out_col, 3);
        chk("r7_data", out_data, 407);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("midreset_frame_done", frame_done, 0);
            chk("midreset_valid", out_valid, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("after_reset_frame_done", frame_done, 0);
            chk("after_reset_valid", out_valid, 0);
        end
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
